// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared size codes, FSM encoding and lane helpers for mem_stage_ext
package mem_stage_pkg;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
  localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Size code 3 is reserved and behaves as a word everywhere.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      MEM_SIZE_BYTE: be = 4'b0001 << lo;
      MEM_SIZE_HALF: be = 4'b0011 << lo;
      default:       be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] lanes;
    case (size)
      MEM_SIZE_BYTE: lanes = {4{data[7:0]}};
      MEM_SIZE_HALF: lanes = {2{data[15:0]}};
      default:       lanes = data;
    endcase
    return lanes;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic uns, input logic [1:0] lo);
    logic [31:0] lane;
    logic [31:0] ext;
    lane = word >> {lo, 3'b000};
    case (size)
      MEM_SIZE_BYTE: ext = uns ? {24'd0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      MEM_SIZE_HALF: ext = uns ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default:       ext = word;
    endcase
    return ext;
  endfunction

endpackage

// File: rtl/mem_stage_ram.sv
// rtl/mem_stage_ram.sv - single-port 4-lane byte-enable RAM with registered, holdable read
module mem_stage_ram
  import mem_stage_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [3:0]    i_be,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [2**AW];
  logic [31:0] r_rdata;

  always_ff @(posedge clock) begin
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  // Read data only moves on a read enable, so a stalled response stays stable.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    r_rdata <= 32'd0;
    else if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_stage_ext.sv
// rtl/mem_stage_ext.sv - MEM stage owning the data RAM: sized loads/stores, valid/ready, INIT clear
// Optional misaligned-access trap: define MEM_STAGE_MISALIGN_TRAP_EN.
module mem_stage_ext
  import mem_stage_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] aluOutput,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] registerRtOrZero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] memoryData,
  output logic        out_misaligned
);

  localparam int WAW = ADDR_WIDTH - 2;
  localparam logic [WAW-1:0] LAST_WORD = '1;

  logic [0:0]     r_state;
  logic [WAW-1:0] r_cnt;
  logic           r_out_valid;
  logic           r_is_load;
  logic [1:0]     r_size;
  logic           r_unsigned;
  logic [1:0]     r_lo;
  logic           r_mis;

  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] w_eff_addr;
  logic                  w_half;
  logic                  w_word;
  logic                  w_mis;
  logic                  w_mis_flag;
  logic                  w_accept;
  logic                  w_store_we;
  logic                  w_load_re;
  logic                  w_init;
  logic                  w_ram_we;
  logic [WAW-1:0]        w_ram_addr;
  logic [3:0]            w_ram_be;
  logic [31:0]           w_ram_wdata;
  logic [31:0]           w_rdata;
  logic                  w_unused;

  assign w_addr = aluOutput[ADDR_WIDTH-1:0];
  assign w_half = (mem_size == MEM_SIZE_HALF);
  assign w_word = (mem_size != MEM_SIZE_BYTE) && !w_half;
  assign w_mis  = (w_half && w_addr[0]) || (w_word && (w_addr[1:0] != 2'b00));

  assign w_init   = (r_state == ST_INIT);
  assign in_ready = reset && !w_init && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  // Trapped accesses touch nothing; the flag travels with the response instead.
  assign w_eff_addr = w_addr;
  assign w_mis_flag = w_mis;
  assign w_unused   = &{1'b0, aluOutput[31:ADDR_WIDTH]};
`else
  assign w_eff_addr = {w_addr[ADDR_WIDTH-1:2],
                       w_addr[1] & !w_word,
                       w_addr[0] & !w_word & !w_half};
  assign w_mis_flag = 1'b0;
  assign w_unused   = &{1'b0, aluOutput[31:ADDR_WIDTH], w_mis};
`endif

  assign w_store_we = w_accept && is_store && !w_mis_flag;
  assign w_load_re  = w_accept && is_load && !w_mis_flag;

  // Gating with reset keeps the INIT sweep from writing while reset is held low.
  assign w_ram_we    = reset && (w_init || w_store_we);
  assign w_ram_addr  = w_init ? r_cnt : w_eff_addr[ADDR_WIDTH-1:2];
  assign w_ram_be    = w_init ? 4'b1111 : byte_en(mem_size, w_eff_addr[1:0]);
  assign w_ram_wdata = w_init ? 32'd0 : store_lanes(mem_size, registerRtOrZero);

  mem_stage_ram #(.AW(WAW)) u_ram (
    .clock   (clock),
    .reset   (reset),
    .i_we    (w_ram_we),
    .i_re    (w_load_re),
    .i_addr  (w_ram_addr),
    .i_be    (w_ram_be),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
      r_cnt   <= '0;
    end else if (w_init) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == LAST_WORD) r_state <= ST_RUN;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_is_load   <= 1'b0;
      r_size      <= MEM_SIZE_WORD;
      r_unsigned  <= 1'b0;
      r_lo        <= 2'b00;
      r_mis       <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_is_load   <= is_load && !is_store && !w_mis_flag;
      r_size      <= mem_size;
      r_unsigned  <= mem_unsigned;
      r_lo        <= w_eff_addr[1:0];
      r_mis       <= w_mis_flag;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid      = r_out_valid;
  assign out_misaligned = r_out_valid && r_mis;
  assign memoryData     = (r_out_valid && r_is_load) ?
                          load_extend(w_rdata, r_size, r_unsigned, r_lo) : 32'd0;

endmodule

// File: tb/tb_mem_stage_ext.sv
// tb/tb_mem_stage_ext.sv - directed self-checking bench for mem_stage_ext
module tb_mem_stage_ext;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] aluOutput = 32'd0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [1:0]  mem_size = 2'd0;
  logic        mem_unsigned = 1'b0;
  logic [31:0] registerRtOrZero = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] memoryData;
  logic        out_misaligned;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  mem_stage_ext #(.ADDR_WIDTH(10), .CLEAR_ON_RESET(1)) dut (
    .clock            (clock),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .aluOutput        (aluOutput),
    .is_load          (is_load),
    .is_store         (is_store),
    .mem_size         (mem_size),
    .mem_unsigned     (mem_unsigned),
    .registerRtOrZero (registerRtOrZero),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .memoryData       (memoryData),
    .out_misaligned   (out_misaligned)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one op, confirm it is accepted, and return #1 after the accept edge.
  task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] data);
    in_valid = 1'b1; is_load = ld; is_store = st; mem_size = sz;
    mem_unsigned = uns; aluOutput = addr; registerRtOrZero = data;
    #1;
    check("accept_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
  endtask

  task automatic wait_init(input string tag);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 2000) begin
      @(posedge clock); #1;
      cyc++;
    end
    check(tag, cyc, 256);
  endtask

  task automatic expect_resp(input string tag, input logic [31:0] data, input logic mis);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"}, memoryData, data);
    check({tag, "_mis"}, {31'd0, out_misaligned}, {31'd0, mis});
  endtask

  initial begin
    #3;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", memoryData, 32'd0);
    check("rst_mis", {31'd0, out_misaligned}, 32'd0);
    #9 reset = 1'b1;
    wait_init("init_cycles");

    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h3FC, 32'd0);
    expect_resp("lw_cleared", 32'h0, 1'b0);

    issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    expect_resp("sw_resp", 32'h0, 1'b0);
    issue(1'b1, 1'b0, 2'd0, 1'b0, 32'h13, 32'd0);
    expect_resp("lb", 32'hFFFFFFDE, 1'b0);
    issue(1'b1, 1'b0, 2'd0, 1'b1, 32'h13, 32'd0);
    expect_resp("lbu", 32'h000000DE, 1'b0);

    issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'hAAAAAAAA);
    issue(1'b0, 1'b1, 2'd1, 1'b0, 32'h22, 32'h00001234);
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
    expect_resp("lw_merge", 32'h1234AAAA, 1'b0);
    issue(1'b1, 1'b0, 2'd1, 1'b0, 32'h22, 32'd0);
    expect_resp("lh_hi", 32'h00001234, 1'b0);
    issue(1'b1, 1'b0, 2'd1, 1'b0, 32'h20, 32'd0);
    expect_resp("lh_lo_sext", 32'hFFFFAAAA, 1'b0);
    issue(1'b0, 1'b1, 2'd0, 1'b0, 32'h31, 32'h000000C3);
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h30, 32'd0);
    expect_resp("sb_lane1", 32'h0000C300, 1'b0);

    // Backpressure: the pending LW @0x20 must hold while a new load waits.
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
    out_ready = 1'b0;
    in_valid = 1'b1; is_load = 1'b1; mem_size = 2'd2; aluOutput = 32'h10;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_data", memoryData, 32'h1234AAAA);
      check("bp_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0; is_load = 1'b0;
    expect_resp("bp_next", 32'hDEADBEEF, 1'b0);

    issue(1'b0, 1'b0, 2'd0, 1'b0, 32'h10, 32'd0);
    expect_resp("bubble", 32'h0, 1'b0);
    @(posedge clock); #1;
    check("idle_valid", {31'd0, out_valid}, 32'd0);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h41, 32'h00000055);
    expect_resp("mis_sw", 32'h0, 1'b1);
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'd0);
    expect_resp("mis_sw_word", 32'h0, 1'b0);
    issue(1'b1, 1'b0, 2'd1, 1'b0, 32'h23, 32'd0);
    expect_resp("mis_lh", 32'h0, 1'b1);
`else
    issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h41, 32'h00000055);
    expect_resp("mis_sw", 32'h0, 1'b0);
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'd0);
    expect_resp("mis_sw_word", 32'h00000055, 1'b0);
    issue(1'b1, 1'b0, 2'd1, 1'b0, 32'h23, 32'd0);
    expect_resp("mis_lh", 32'h00001234, 1'b0);
`endif

    // Reset during a load response, then confirm INIT re-clears the RAM.
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    check("pre_rst_data", memoryData, 32'hDEADBEEF);
    reset = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_data", memoryData, 32'd0);
    check("async_rst_ready", {31'd0, in_ready}, 32'd0);
    #5 reset = 1'b1;
    wait_init("reinit_cycles");
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    expect_resp("reinit_lw", 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
